// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: the display always owns the single-port RAM when it asks;
// the coprocessor gets every remaining cycle. Reads return through a tag pipeline
// aligned with the RAM latency, and a sticky flag reports coprocessor starvation.
module vga_fb_arbiter #(
   parameter int ADDR_W       = 17,
   parameter int DATA_W       = 8,
   parameter int RD_LAT       = 1,
   parameter int STARVE_LIMIT = 1024
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              DISP_REQ,
   input  logic [ADDR_W-1:0] DISP_ADDR,
   output logic              DISP_RVALID,
   output logic [DATA_W-1:0] DISP_RDATA,
   input  logic              CP_REQ,
   input  logic              CP_WE,
   input  logic [ADDR_W-1:0] CP_ADDR,
   input  logic [DATA_W-1:0] CP_WDATA,
   output logic              CP_GNT,
   output logic              CP_RVALID,
   output logic [DATA_W-1:0] CP_RDATA,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic              MEM_WE,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA,
   output logic              STARVE_ERR
);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_DISP = 2'd1;
   localparam logic [1:0] OWN_CP   = 2'd2;

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [1:0]        r_own;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_we;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [1:0]        r_tag [1:RD_LAT];
   logic              r_disp_rvalid;
   logic [DATA_W-1:0] r_disp_rdata;
   logic              r_cp_rvalid;
   logic [DATA_W-1:0] r_cp_rdata;
   logic [CNT_W-1:0]  r_starve_cnt;
   logic              r_starve_err;

   logic [1:0]        w_tag0;
   logic [1:0]        w_tag_end;
   logic [CNT_W-1:0]  w_cnt_inc;

   assign CP_GNT      = CP_REQ & ~DISP_REQ & ~RST;
   assign MEM_ADDR    = r_mem_addr;
   assign MEM_WE      = r_mem_we;
   assign MEM_WDATA   = r_mem_wdata;
   assign DISP_RVALID = r_disp_rvalid;
   assign DISP_RDATA  = r_disp_rdata;
   assign CP_RVALID   = r_cp_rvalid;
   assign CP_RDATA    = r_cp_rdata;
   assign STARVE_ERR  = r_starve_err;

   // The owner register doubles as tag stage 0: it is valid in the same cycle
   // as the registered MEM_ADDR, so only RD_LAT further stages are needed.
   assign w_tag0    = {r_own == OWN_DISP, (r_own == OWN_CP) & ~r_mem_we};
   assign w_tag_end = r_tag[RD_LAT];

   assign w_cnt_inc = (r_starve_cnt == CNT_MAX) ? r_starve_cnt : r_starve_cnt + 1'b1;

   // Owner selection and registered RAM command; address holds when idle
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_own       <= OWN_NONE;
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
      end else if (DISP_REQ) begin
         r_own      <= OWN_DISP;
         r_mem_addr <= DISP_ADDR;
         r_mem_we   <= 1'b0;
      end else if (CP_REQ) begin
         r_own       <= OWN_CP;
         r_mem_addr  <= CP_ADDR;
         r_mem_we    <= CP_WE;
         r_mem_wdata <= CP_WDATA;
      end else begin
         r_own    <= OWN_NONE;
         r_mem_we <= 1'b0;
      end
   end

   // Read tag pipeline, end stage lines up with valid MEM_RDATA
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int unsigned i = 1; i <= RD_LAT; i++) r_tag[i] <= '0;
      end else begin
         r_tag[1] <= w_tag0;
         for (int unsigned i = 2; i <= RD_LAT; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   // Capture returning read data into the tagged requester's outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_disp_rvalid <= 1'b0;
         r_disp_rdata  <= '0;
         r_cp_rvalid   <= 1'b0;
         r_cp_rdata    <= '0;
      end else begin
         r_disp_rvalid <= w_tag_end[1];
         r_cp_rvalid   <= w_tag_end[0];
         if (w_tag_end[1]) r_disp_rdata <= MEM_RDATA;
         if (w_tag_end[0]) r_cp_rdata   <= MEM_RDATA;
      end
   end

   // Saturating count of blocked coprocessor cycles and sticky error flag
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_starve_cnt <= '0;
         r_starve_err <= 1'b0;
      end else if (CP_REQ & DISP_REQ) begin
         r_starve_cnt <= w_cnt_inc;
         if (w_cnt_inc == CNT_MAX) r_starve_err <= 1'b1;
      end else begin
         r_starve_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: table of per-cycle vectors plus hand sequences for
// starvation and reset-in-flight; read results checked through a scoreboard queue.
module tb_vga_fb_arbiter;

   localparam int ADDR_W = 17;
   localparam int DATA_W = 8;
   localparam int RD_LAT = 1;
   localparam int LIM    = 8;

   logic              clk;
   logic              rst;
   logic              dreq;
   logic [ADDR_W-1:0] daddr;
   logic              drvalid;
   logic [DATA_W-1:0] drdata;
   logic              creq;
   logic              cwe;
   logic [ADDR_W-1:0] caddr;
   logic [DATA_W-1:0] cwdata;
   logic              cgnt;
   logic              crvalid;
   logic [DATA_W-1:0] crdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              starve_err;

   vga_fb_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .RD_LAT      (RD_LAT),
      .STARVE_LIMIT(LIM)
   ) dut (
      .CLK        (clk),
      .RST        (rst),
      .DISP_REQ   (dreq),
      .DISP_ADDR  (daddr),
      .DISP_RVALID(drvalid),
      .DISP_RDATA (drdata),
      .CP_REQ     (creq),
      .CP_WE      (cwe),
      .CP_ADDR    (caddr),
      .CP_WDATA   (cwdata),
      .CP_GNT     (cgnt),
      .CP_RVALID  (crvalid),
      .CP_RDATA   (crdata),
      .MEM_ADDR   (mem_addr),
      .MEM_WE     (mem_we),
      .MEM_WDATA  (mem_wdata),
      .MEM_RDATA  (mem_rdata),
      .STARVE_ERR (starve_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model with one cycle read latency
   logic [DATA_W-1:0] ram  [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] refm [0:(1<<ADDR_W)-1];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   typedef struct {
      logic              rst;
      logic              dreq;
      logic [ADDR_W-1:0] daddr;
      logic              creq;
      logic              cwe;
      logic [ADDR_W-1:0] caddr;
      logic [DATA_W-1:0] cwdata;
      logic              exp_gnt;
   } vec_t;

   typedef struct {
      bit                is_cp;
      logic [DATA_W-1:0] data;
      int                due;
   } exp_t;

   exp_t sbq[$];
   vec_t tab[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [ADDR_W-1:0] e_addr  = '0;
   logic              e_we    = 1'b0;
   logic [DATA_W-1:0] e_wdata = '0;
   logic [DATA_W-1:0] e_drd   = '0;
   logic [DATA_W-1:0] e_crd   = '0;
   int                e_cnt   = 0;
   logic              e_err   = 1'b0;

   function automatic vec_t mk(bit r, bit dq, int da, bit cq, bit cw, int ca, int wd, bit g);
      vec_t v;
      v.rst = r; v.dreq = dq; v.daddr = da[ADDR_W-1:0];
      v.creq = cq; v.cwe = cw; v.caddr = ca[ADDR_W-1:0];
      v.cwdata = wd[DATA_W-1:0]; v.exp_gnt = g;
      return v;
   endfunction

   function automatic vec_t idle();
      return mk(0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   function void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", nm, cyc, act, exp);
      end
   endfunction

   function void push_exp(bit is_cp, logic [DATA_W-1:0] d);
      exp_t e;
      e.is_cp = is_cp;
      e.data  = d;
      e.due   = cyc + RD_LAT + 2;
      sbq.push_back(e);
   endfunction

   task automatic check_outputs();
      logic exp_dv;
      logic exp_cv;
      exp_t e;
      exp_dv = 1'b0;
      exp_cv = 1'b0;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         e = sbq.pop_front();
         if (e.is_cp) begin exp_cv = 1'b1; e_crd = e.data; end
         else         begin exp_dv = 1'b1; e_drd = e.data; end
      end
      chk("mem_addr",    32'(mem_addr),   32'(e_addr));
      chk("mem_we",      32'(mem_we),     32'(e_we));
      chk("mem_wdata",   32'(mem_wdata),  32'(e_wdata));
      chk("disp_rvalid", 32'(drvalid),    32'(exp_dv));
      chk("cp_rvalid",   32'(crvalid),    32'(exp_cv));
      chk("disp_rdata",  32'(drdata),     32'(e_drd));
      chk("cp_rdata",    32'(crdata),     32'(e_crd));
      chk("starve_err",  32'(starve_err), 32'(e_err));
   endtask

   // Drive one cycle, check the grant, update the model, then check registered outputs
   task automatic drive_cycle(input vec_t v);
      rst = v.rst; dreq = v.dreq; daddr = v.daddr;
      creq = v.creq; cwe = v.cwe; caddr = v.caddr; cwdata = v.cwdata;
      #1;
      chk("cp_gnt", 32'(cgnt), 32'(v.exp_gnt));
      if (v.rst) begin
         sbq.delete();
         e_addr = '0; e_we = 1'b0; e_wdata = '0;
         e_drd = '0; e_crd = '0; e_cnt = 0; e_err = 1'b0;
      end else begin
         if (v.dreq) begin
            e_addr = v.daddr; e_we = 1'b0;
            push_exp(1'b0, refm[v.daddr]);
         end else if (v.creq) begin
            e_addr = v.caddr; e_we = v.cwe; e_wdata = v.cwdata;
            if (v.cwe) refm[v.caddr] = v.cwdata;
            else       push_exp(1'b1, refm[v.caddr]);
         end else begin
            e_we = 1'b0;
         end
         if (v.creq && v.dreq) begin
            if (e_cnt < LIM) e_cnt++;
            if (e_cnt == LIM) e_err = 1'b1;
         end else begin
            e_cnt = 0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; dreq = 1'b1; daddr = '0;
      creq = 1'b1; cwe = 1'b0; caddr = '0; cwdata = '0;
      for (int a = 0; a < (1 << ADDR_W); a++) begin
         ram[a]  = a[7:0] ^ 8'h3C;
         refm[a] = a[7:0] ^ 8'h3C;
      end
      ram[17'h00123]  = 8'h5A;
      refm[17'h00123] = 8'h5A;

      // reset with both requests high
      tab.push_back(mk(1, 1, 'h00000, 1, 0, 'h00200, 'h00, 0));
      tab.push_back(mk(1, 1, 'h00000, 1, 0, 'h00200, 'h00, 0));
      // display read of 0x00123, three-cycle return
      tab.push_back(mk(0, 1, 'h00123, 0, 0, 'h00000, 'h00, 0));
      tab.push_back(idle()); tab.push_back(idle()); tab.push_back(idle());
      // collision: display wins, CP read granted next cycle
      tab.push_back(mk(0, 1, 'h00040, 1, 0, 'h00200, 'h00, 0));
      tab.push_back(mk(0, 0, 'h00000, 1, 0, 'h00200, 'h00, 1));
      tab.push_back(idle()); tab.push_back(idle()); tab.push_back(idle());
      // CP write at top address, then read it back
      tab.push_back(mk(0, 0, 'h00000, 1, 1, 'h1FFFF, 'hA5, 1));
      tab.push_back(idle());
      tab.push_back(mk(0, 0, 'h00000, 1, 0, 'h1FFFF, 'h00, 1));
      tab.push_back(idle()); tab.push_back(idle()); tab.push_back(idle());
      // back-to-back display reads with a blocked CP read behind them
      tab.push_back(mk(0, 1, 'h00010, 1, 0, 'h00300, 'h00, 0));
      tab.push_back(mk(0, 1, 'h00011, 1, 0, 'h00300, 'h00, 0));
      tab.push_back(mk(0, 1, 'h00012, 1, 0, 'h00300, 'h00, 0));
      tab.push_back(mk(0, 0, 'h00000, 1, 0, 'h00300, 'h00, 1));
      // CP write then display reads it, interleaved CP read
      tab.push_back(mk(0, 0, 'h00000, 1, 1, 'h00010, 'h77, 1));
      tab.push_back(mk(0, 1, 'h00010, 0, 0, 'h00000, 'h00, 0));
      tab.push_back(mk(0, 0, 'h00000, 1, 0, 'h00011, 'h00, 1));
      tab.push_back(mk(0, 1, 'h1FFFF, 0, 0, 'h00000, 'h00, 0));
      tab.push_back(idle()); tab.push_back(idle()); tab.push_back(idle());
      tab.push_back(idle());

      foreach (tab[i]) drive_cycle(tab[i]);

      // starvation: display hogs the RAM past the limit, then releases
      for (int i = 0; i < LIM + 2; i++)
         drive_cycle(mk(0, 1, 'h00400 + i, 1, 0, 'h00055, 'h00, 0));
      drive_cycle(mk(0, 0, 'h00000, 1, 0, 'h00055, 'h00, 1));
      for (int i = 0; i < 4; i++) drive_cycle(idle());
      chk("starve_sticky", 32'(starve_err), 32'(1));
      drive_cycle(mk(1, 0, 'h00000, 0, 0, 'h00000, 'h00, 0));
      chk("starve_cleared", 32'(starve_err), 32'(0));

      // reset while a display read is in flight, then a fresh read
      drive_cycle(mk(0, 1, 'h00123, 0, 0, 'h00000, 'h00, 0));
      drive_cycle(mk(1, 0, 'h00000, 1, 0, 'h00200, 'h00, 0));
      for (int i = 0; i < 4; i++) drive_cycle(idle());
      drive_cycle(mk(0, 1, 'h00124, 0, 0, 'h00000, 'h00, 0));
      for (int i = 0; i < 4; i++) drive_cycle(idle());

      chk("scoreboard_drained", 32'(sbq.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
